fetch_brdec_ras: RTL



---
 rtl/fetch_brdec_ras.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_brdec_ras.sv
// Fetch-group branch predecoder with a checkpointable circular return-address
// stack. Picks the first predicted-taken transfer of the group, computes its
// target, applies that way's RAS action and registers the result for fetch 2.
module fetch_brdec_ras #(
  parameter  int unsigned WAYS      = 4,
  parameter  int unsigned RAS_DEPTH = 8,
  parameter  int unsigned XLEN      = 64,
  localparam int unsigned PW        = $clog2(RAS_DEPTH),
  localparam int unsigned WW        = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                grp_vld_i,
  input  logic                stall_i,
  input  logic [XLEN-1:0]     grp_pc_i,
  input  logic [32*WAYS-1:0]  grp_inst_i,
  input  logic [WAYS-1:0]     bht_taken_i,
  input  logic                recover_i,
  input  logic [2*PW:0]       recover_ckpt_i,
  output logic                out_vld_o,
  output logic                br_taken_o,
  output logic [WW-1:0]       br_way_o,
  output logic [1:0]          br_typ_o,
  output logic [XLEN-1:0]     br_tar_o,
  output logic [WAYS-1:0]     br_mask_o,
  output logic [1:0]          ras_ctl_o,
  output logic                ras_underflow_o,
  output logic [2*PW:0]       ras_ckpt_o
);

  typedef enum logic [1:0] {TYP_COND, TYP_UNCOND, TYP_INDIR, TYP_RET} br_typ_e;
  typedef enum logic [1:0] {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH} ras_op_e;

  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx;
  logic [PW:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty, ras_full;

  logic            found;
  logic [WW-1:0]   sel_way;
  br_typ_e         sel_typ;
  ras_op_e         sel_op;
  logic [XLEN-1:0] sel_tar, sel_link;
  logic [WAYS-1:0] mask_d;

  logic            wr_en, unf_d;
  logic [PW-1:0]   wr_idx;

  logic                out_vld_q, br_taken_q, ras_unf_q;
  logic [WW-1:0]       br_way_q;
  logic [1:0]          br_typ_q, ras_ctl_q;
  logic [XLEN-1:0]     br_tar_q;
  logic [WAYS-1:0]     br_mask_q;
  logic [2*PW:0]       ras_ckpt_q;

  assign top_idx   = ptr_q - PW'(1);
  assign ras_top   = ras_mem_q[top_idx];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == (PW+1)'(RAS_DEPTH));

  // Per-way decode and lowest-index taken-way selection
  always_comb begin
    mask_d   = '0;
    found    = 1'b0;
    sel_way  = '0;
    sel_typ  = TYP_COND;
    sel_op   = RAS_NONE;
    sel_tar  = '0;
    sel_link = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      logic [31:0]     inst;
      logic [XLEN-1:0] wpc, w_tar;
      logic            rd_lnk, rs_lnk, w_br, w_tk;
      br_typ_e         w_typ;
      ras_op_e         w_op;
      inst   = grp_inst_i[32*k +: 32];
      wpc    = grp_pc_i + XLEN'(4*k);
      rd_lnk = (inst[11:7] == 5'd1) || (inst[11:7] == 5'd5);
      rs_lnk = (inst[19:15] == 5'd1) || (inst[19:15] == 5'd5);
      w_br   = 1'b0;
      w_tk   = 1'b0;
      w_typ  = TYP_COND;
      w_op   = RAS_NONE;
      w_tar  = '0;
      if (inst[6:0] == 7'b1100011 && inst[14:13] != 2'b01) begin
        w_br  = 1'b1;
        w_tk  = bht_taken_i[k];
        w_tar = wpc + {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                       inst[11:8], 1'b0};
      end else if (inst[6:0] == 7'b1101111) begin
        w_br  = 1'b1;
        w_tk  = 1'b1;
        w_typ = TYP_UNCOND;
        w_op  = rd_lnk ? RAS_PUSH : RAS_NONE;
        w_tar = wpc + {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                       inst[30:21], 1'b0};
      end else if (inst[6:0] == 7'b1100111 && inst[14:12] == 3'b000) begin
        w_br = 1'b1;
        w_tk = 1'b1;
        // A return needs rs1 linked and, if rd is also linked, a different one;
        // every other JALR is an indirect jump that pushes when rd is linked.
        if (rs_lnk && (!rd_lnk || inst[11:7] != inst[19:15])) begin
          w_typ = TYP_RET;
          w_op  = rd_lnk ? RAS_POPPUSH : RAS_POP;
          w_tar = ras_empty ? '0 : ras_top;
        end else begin
          w_typ = TYP_INDIR;
          w_op  = rd_lnk ? RAS_PUSH : RAS_NONE;
          w_tar = {{(XLEN-12){inst[31]}}, inst[31:20]};
        end
      end
      mask_d[k] = w_br;
      if (w_tk && !found) begin
        found    = 1'b1;
        sel_way  = WW'(k);
        sel_typ  = w_typ;
        sel_op   = w_op;
        sel_tar  = w_tar;
        sel_link = wpc + XLEN'(4);
      end
    end
  end

  // Next RAS pointer/count and the single entry write for the winning way
  always_comb begin
    logic do_push;
    do_push = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    unf_d   = 1'b0;
    if (found) begin
      unique case (sel_op)
        RAS_PUSH: do_push = 1'b1;
        RAS_POP: begin
          if (ras_empty) unf_d = 1'b1;
          else begin
            ptr_d = top_idx;
            cnt_d = cnt_q - (PW+1)'(1);
          end
        end
        RAS_POPPUSH: begin
          if (ras_empty) begin
            unf_d   = 1'b1;
            do_push = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
          end
        end
        default: ;
      endcase
    end
    if (do_push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      cnt_d = ras_full ? cnt_q : cnt_q + (PW+1)'(1);
    end
  end

  // RAS state and registered outputs; recover outranks stall and accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
      out_vld_q  <= 1'b0;
      br_taken_q <= 1'b0;
      br_way_q   <= '0;
      br_typ_q   <= '0;
      br_tar_q   <= '0;
      br_mask_q  <= '0;
      ras_ctl_q  <= '0;
      ras_unf_q  <= 1'b0;
      ras_ckpt_q <= '0;
    end else if (recover_i) begin
      ptr_q     <= recover_ckpt_i[PW-1:0];
      cnt_q     <= recover_ckpt_i[2*PW:PW];
      out_vld_q <= 1'b0;
    end else if (!stall_i) begin
      out_vld_q <= grp_vld_i;
      if (grp_vld_i) begin
        ptr_q      <= ptr_d;
        cnt_q      <= cnt_d;
        if (wr_en) ras_mem_q[wr_idx] <= sel_link;
        br_taken_q <= found;
        br_way_q   <= sel_way;
        br_typ_q   <= sel_typ;
        br_tar_q   <= sel_tar;
        br_mask_q  <= mask_d;
        ras_ctl_q  <= sel_op;
        ras_unf_q  <= unf_d;
        ras_ckpt_q <= {cnt_q, ptr_q};
      end
    end
  end

  assign out_vld_o       = out_vld_q;
  assign br_taken_o      = br_taken_q;
  assign br_way_o        = br_way_q;
  assign br_typ_o        = br_typ_q;
  assign br_tar_o        = br_tar_q;
  assign br_mask_o       = br_mask_q;
  assign ras_ctl_o       = ras_ctl_q;
  assign ras_underflow_o = ras_unf_q;
  assign ras_ckpt_o      = ras_ckpt_q;

endmodule
